// File: rtl/readout_sequencer.sv
// readout_sequencer
// Sequences one readout frame of the counter datapath (four channel counters
// plus the RTC counter). For each word it selects the mux input, has the PISO
// register capture it in parallel, and then shifts it out serially. After the
// last word it pulses the counter clear.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   enable       gates frame starts; a running frame always completes
//   ovf_RTC      RTC counter overflow (level)
//   ovf_ch       OR of the channel counter overflows (level)
//   read_req     host readout request (level or pulse)
//   sel          5:1 mux select (0..3 = ch1..ch4, 4 = RTC)
//   SL           PISO control, 0 = parallel load, 1 = shift
//   shift_en     high while a serial bit is valid at the PISO output
//   out_rst      counter clear pulse at the end of a frame
//   busy         high from the first SEL cycle through the DONE cycle
//   frame_start  one-cycle pulse on the first SEL cycle of a frame
//   done         one-cycle pulse at the end of a frame
//
// state | meaning
// IDLE  | waiting for a trigger
// SEL   | mux select settling for the current word
// LOAD  | PISO parallel capture
// SHIFT | WORD_W serial bits; the next-word decision is made on the last one
// NEXT  | decision point folded into the last SHIFT cycle, never occupied
// CLR   | out_rst pulse, RST_PULSE cycles
// DONE  | end-of-frame pulse, returns to IDLE
module readout_sequencer #(
    parameter int N_WORDS   = 5,
    parameter int WORD_W    = 12,
    parameter int RST_PULSE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ovf_RTC,
    input  logic       ovf_ch,
    input  logic       read_req,
    output logic [2:0] sel,
    output logic       SL,
    output logic       shift_en,
    output logic       out_rst,
    output logic       busy,
    output logic       frame_start,
    output logic       done
);

    // One counter serves both the SHIFT bit count and the CLR pulse width.
    localparam int CNT_MAX = (WORD_W > RST_PULSE) ? WORD_W : RST_PULSE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_LOAD,
        S_SHIFT,
        S_NEXT,
        S_CLR,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic [2:0]       sel_q, sel_d;
    logic             sl_q, sl_d;
    logic             shift_en_q, shift_en_d;
    logic             out_rst_q, out_rst_d;
    logic             busy_q, busy_d;
    logic             frame_start_q, frame_start_d;
    logic             done_q, done_d;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        cnt_d      = cnt_q;
        // Only host requests are remembered during a frame; overflows are
        // dropped because the end-of-frame clear removes their cause.
        pending_d  = pending_q | (busy_q & read_req);

        case (state_q)
            S_IDLE: begin
                if (enable & (ovf_RTC | ovf_ch | read_req | pending_q)) begin
                    state_d    = S_SEL;
                    pending_d  = 1'b0;
                    word_cnt_d = '0;
                end
            end
            S_SEL: state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_SHIFT;
                cnt_d   = '0;
            end
            S_SHIFT: begin
                if (cnt_q == CNT_W'(WORD_W - 1)) begin
                    cnt_d = '0;
                    if (word_cnt_q < 3'(N_WORDS - 1)) begin
                        word_cnt_d = word_cnt_q + 3'd1;
                        state_d    = S_SEL;
                    end else begin
                        state_d = S_CLR;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CLR: begin
                if (cnt_q == CNT_W'(RST_PULSE - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step
        // with the state they describe.
        sl_d          = (state_d != S_LOAD);
        shift_en_d    = (state_d == S_SHIFT);
        out_rst_d     = (state_d == S_CLR);
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
        frame_start_d = (state_d == S_SEL) && (word_cnt_d == 3'd0);
        if (state_d == S_SEL) begin
            sel_d = word_cnt_d;
        end else if ((state_d == S_DONE) || (state_d == S_IDLE)) begin
            sel_d = 3'd0;
        end else begin
            sel_d = sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            word_cnt_q    <= '0;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            sel_q         <= 3'd0;
            sl_q          <= 1'b1;
            shift_en_q    <= 1'b0;
            out_rst_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            word_cnt_q    <= word_cnt_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            sel_q         <= sel_d;
            sl_q          <= sl_d;
            shift_en_q    <= shift_en_d;
            out_rst_q     <= out_rst_d;
            busy_q        <= busy_d;
            frame_start_q <= frame_start_d;
            done_q        <= done_d;
        end
    end

    assign sel         = sel_q;
    assign SL          = sl_q;
    assign shift_en    = shift_en_q;
    assign out_rst     = out_rst_q;
    assign busy        = busy_q;
    assign frame_start = frame_start_q;
    assign done        = done_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// tb_readout_sequencer
// Directed bench for readout_sequencer. A behavioural PISO fed by a fixed
// 5:1 mux sits behind the DUT so the serial stream can be compared with the
// loaded counter values.
module tb_readout_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       ovf_RTC;
    logic       ovf_ch;
    logic       read_req;
    logic [2:0] sel;
    logic       SL;
    logic       shift_en;
    logic       out_rst;
    logic       busy;
    logic       frame_start;
    logic       done;

    readout_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .ovf_RTC     (ovf_RTC),
        .ovf_ch      (ovf_ch),
        .read_req    (read_req),
        .sel         (sel),
        .SL          (SL),
        .shift_en    (shift_en),
        .out_rst     (out_rst),
        .busy        (busy),
        .frame_start (frame_start),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Mux + PISO model, MSB shifted out first.
    logic [11:0] mux_out;
    logic [11:0] piso;
    always_comb begin
        case (sel)
            3'd0:    mux_out = 12'h123;
            3'd1:    mux_out = 12'h456;
            3'd2:    mux_out = 12'h789;
            3'd3:    mux_out = 12'hABC;
            3'd4:    mux_out = 12'h2C5;
            default: mux_out = 12'h000;
        endcase
    end
    always @(posedge clk) begin
        if (!SL) piso <= mux_out;
        else     piso <= {piso[10:0], 1'b0};
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Per-window statistics filled by watch().
    int          busy_cnt, shift_cnt, rst_cnt, done_cnt, fs_cnt;
    int          first_rst, first_done;
    int          fs_at [0:3];
    logic [2:0]  sel_log  [0:199];
    logic        sl_log   [0:199];
    logic        busy_log [0:199];
    logic        sh_log   [0:199];
    logic [59:0] stream;
    logic        rr_hold;

    // Samples ncyc cycles; cycle 1 is the current negedge. Stimulus for the
    // following posedge is driven after each sample.
    task automatic watch(input int ncyc, input int rr1, input int rr2,
                         input int en_drop, input int rst_at, input int ovf_drop);
        busy_cnt = 0; shift_cnt = 0; rst_cnt = 0; done_cnt = 0; fs_cnt = 0;
        first_rst = 0; first_done = 0; stream = '0;
        for (int k = 0; k < 4; k++) fs_at[k] = 0;
        for (int i = 1; i <= ncyc; i++) begin
            if (i > 1) @(negedge clk);
            sel_log[i]  = sel;
            sl_log[i]   = SL;
            busy_log[i] = busy;
            sh_log[i]   = shift_en;
            if (busy) busy_cnt++;
            if (shift_en) begin
                shift_cnt++;
                stream = {stream[58:0], piso[11]};
            end
            if (out_rst) begin
                rst_cnt++;
                if (first_rst == 0) first_rst = i;
            end
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = i;
            end
            if (frame_start) begin
                if (fs_cnt < 4) fs_at[fs_cnt] = i;
                fs_cnt++;
            end
            read_req = rr_hold | (i == rr1) | (i == rr2);
            reset    = (i == rst_at);
            if (en_drop != 0 && i >= en_drop) enable = 1'b0;
            if (i == ovf_drop) begin
                ovf_RTC = 1'b0;
                ovf_ch  = 1'b0;
            end
        end
    endtask

    // Pulses read_req in an idle cycle so the next negedge is busy cycle 1.
    task automatic kick_read;
        read_req = 1'b1;
        @(negedge clk);
        read_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; ovf_RTC = 1'b0; ovf_ch = 1'b0;
        read_req = 1'b0; rr_hold = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sel", sel, 0);
        check("rst_sl", SL, 1);
        check("rst_flags", {shift_en, out_rst, busy, frame_start, done}, 5'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single host request: full frame timing and serial contents.
        kick_read();
        watch(80, 0, 0, 0, 0, 0);
        check("t1_fs_at", fs_at[0], 1);
        check("t1_fs_cnt", fs_cnt, 1);
        check("t1_sl_load", sl_log[2], 0);
        check("t1_sl_sel", sl_log[1], 1);
        for (int w = 0; w < 5; w++)
            check($sformatf("t1_sel_w%0d", w), sel_log[14*w+1], w);
        check("t1_shift_cnt", shift_cnt, 60);
        check("t1_first_rst", first_rst, 71);
        check("t1_rst_cnt", rst_cnt, 2);
        check("t1_sel_clr", sel_log[72], 4);
        check("t1_done_at", first_done, 73);
        check("t1_sel_done", sel_log[73], 0);
        check("t1_busy_cnt", busy_cnt, 73);
        check("t1_busy_after", busy_log[74], 0);
        check("t1_stream", stream, {12'h123, 12'h456, 12'h789, 12'hABC, 12'h2C5});
        repeat (3) @(negedge clk);

        // Both overflows together, held until the clear pulse.
        ovf_RTC = 1'b1; ovf_ch = 1'b1;
        @(negedge clk);
        watch(110, 0, 0, 0, 0, 72);
        check("t2_fs_cnt", fs_cnt, 1);
        check("t2_busy_cnt", busy_cnt, 73);
        check("t2_done_cnt", done_cnt, 1);
        repeat (3) @(negedge clk);

        // Two requests during a frame merge into one follow-up frame.
        kick_read();
        watch(170, 30, 40, 0, 0, 0);
        check("t3_fs_cnt", fs_cnt, 2);
        check("t3_fs2_at", fs_at[1], 75);
        check("t3_done_cnt", done_cnt, 2);
        check("t3_busy_cnt", busy_cnt, 146);
        check("t3_rst_cnt", rst_cnt, 4);
        repeat (3) @(negedge clk);

        // Disabled: a held request does nothing.
        enable = 1'b0; rr_hold = 1'b1;
        watch(20, 0, 0, 0, 0, 0);
        check("t4_dis_busy", busy_cnt, 0);
        check("t4_dis_fs", fs_cnt, 0);
        rr_hold = 1'b0; read_req = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);

        // enable dropped mid-frame: frame still completes.
        kick_read();
        watch(90, 0, 0, 20, 0, 0);
        check("t4_drop_rst", rst_cnt, 2);
        check("t4_drop_done", first_done, 73);
        check("t4_drop_busy", busy_cnt, 73);
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // Reset at busy cycle 35 with a pending request outstanding.
        kick_read();
        watch(120, 30, 0, 0, 35, 0);
        check("t5_sel_pre", sel_log[35], 2);
        check("t5_sh_pre", sh_log[35], 1);
        check("t5_sel_post", sel_log[36], 0);
        check("t5_sl_post", sl_log[36], 1);
        check("t5_busy_post", busy_log[36], 0);
        check("t5_sh_post", sh_log[36], 0);
        check("t5_rst_cnt", rst_cnt, 0);
        check("t5_done_cnt", done_cnt, 0);
        check("t5_fs_cnt", fs_cnt, 1);
        check("t5_busy_cnt", busy_cnt, 35);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/readout_sequencer.md
Name: readout_sequencer

Overview:
- Sequences one readout frame of the counter datapath: the four channel counters plus the RTC counter.
- For each word it drives the 5:1 mux select, loads the PISO register, then shifts the word out serially.
- After the last word it pulses the counter clear (`out_rst`).
- A frame is started by RTC overflow, by any channel overflow, or by an explicit host read request. The block takes the place of the existing FSM between the counters/muxes and the PISO register.

Parameters:
- N_WORDS, 5, number of words per frame; `sel` counts 0..N_WORDS-1 (0=ch1, 1=ch2, 2=ch3, 3=ch4, 4=RTC).
- WORD_W, 12, bits shifted per word; must match the PISO width.
- RST_PULSE, 2, width of the `out_rst` pulse in clk cycles (minimum 1).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  when 0, no new frame starts; a frame already in progress completes.
- ovf_RTC  in  1  RTC counter overflow (level).
- ovf_ch  in  1  OR of the channel counter overflows (level).
- read_req  in  1  host readout request (level or pulse, sampled every cycle).
- sel  out  3  mux select {a2,a1,a0}.
- SL  out  1  PISO control: 0 = parallel load, 1 = shift.
- shift_en  out  1  high on every cycle that a serial bit is valid at the PISO output.
- out_rst  out  1  counter clear pulse.
- busy  out  1  high from the first SEL cycle through the DONE cycle.
- frame_start  out  1  one-cycle pulse on the first SEL cycle of a frame.
- done  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset values: sel=0, SL=1, shift_en=0, out_rst=0, busy=0, frame_start=0, done=0. State=IDLE, word_cnt=0, bit_cnt=0, pending=0.
- The state machine has seven states: IDLE, SEL, LOAD, SHIFT, NEXT, CLR, DONE.
- IDLE:
  - Trigger = enable & (ovf_RTC | ovf_ch | read_req | pending).
  - On trigger: go to SEL, clear pending, set word_cnt=0.
- SEL (1 cycle, mux settle):
  - sel=word_cnt, SL=1, busy=1.
  - frame_start=1 only when word_cnt=0.
  - Goes to LOAD.
- LOAD (1 cycle): SL=0 (PISO captures the mux outputs). Goes to SHIFT with bit_cnt=0.
- SHIFT (exactly WORD_W cycles):
  - SL=1, shift_en=1; bit_cnt increments each cycle.
  - When bit_cnt=WORD_W-1, go to NEXT.
- NEXT (0-cycle decision, folded into the last SHIFT cycle):
  - If word_cnt<N_WORDS-1: word_cnt+1, go to SEL.
  - Otherwise go to CLR.
- CLR: out_rst=1 for RST_PULSE cycles; sel holds at the last value.
- DONE (1 cycle): done=1, busy=1, sel returns to 0. Goes to IDLE.
- Timing:
  - Trigger sampled in IDLE at cycle t, first SEL at t+1.
  - Per word: 1 (SEL) + 1 (LOAD) + WORD_W (SHIFT) = 14 cycles at defaults.
  - Frame = N_WORDS·(WORD_W+2) + RST_PULSE + 1 = 73 cycles at defaults, from the first busy cycle to the last.
- Triggers during a frame:
  - A read_req that arrives while busy=1 sets pending. One pending request is held; extra requests merge into it.
  - The pending request starts a new frame on the cycle after DONE (IDLE is held for 1 cycle).
  - ovf_RTC and ovf_ch are ignored while busy, because the end-of-frame out_rst clears their source.
- Simultaneous triggers start a single frame; there is no priority between them.
- A trigger seen in the same cycle as DONE goes into pending only if it is read_req.
- enable drops mid-frame: the frame completes, including out_rst. pending is retained but does not start a frame until enable=1.
- reset during a frame:
  - Next cycle all outputs are at their reset values.
  - No out_rst pulse, no done pulse, pending cleared.

Test Plan:
- Single read_req pulse at idle, enable=1 -> busy rises next cycle with frame_start=1 and sel=0. SL=0 on the second busy cycle. sel steps 0,1,2,3,4 every 14 cycles. shift_en is high for 60 cycles in total. out_rst is high for 2 cycles at busy cycles 71–72. done at cycle 73, then busy=0.
- ovf_RTC and ovf_ch both asserted in the same cycle -> exactly one 73-cycle frame. A held ovf level that falls after out_rst does not start a second frame.
- read_req pulsed at busy cycle 30, then again at cycle 40 -> exactly one extra frame, whose frame_start comes 2 cycles after the first done.
- enable=0 with read_req high -> no activity. enable is dropped at busy cycle 20 -> the frame still completes with out_rst and done.
- reset asserted at busy cycle 35 (sel=2, SHIFT) -> next cycle sel=0, SL=1, busy=0, shift_en=0. No out_rst and no done pulse appear.
- Per-word check against a PISO model loaded with counts 0x123, 0x456, 0x789, 0xABC and RTC=0x2C5 -> the serial stream reproduces these 5×12 bits in sel order.
